// File: rtl/hazard_bypass_unit.sv
// Stateful ID/EX forwarding and hazard unit: tracks in-flight writers in a shift
// pipeline, produces per-operand bypass selects and a stall for not-yet-ready producers.
module hazard_bypass_unit #(
    parameter int NUM_SRC        = 2,
    parameter int NUM_FWD_STAGES = 2,
    parameter int LAT_W          = $clog2(NUM_FWD_STAGES + 1),
    parameter int SEL_W          = $clog2(NUM_FWD_STAGES + 1),
    parameter int CNT_W          = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     hold_i,
    input  logic                     issue_valid_i,
    input  logic [4:0]               issue_rd_i,
    input  logic                     issue_reg_write_en,
    input  logic [LAT_W-1:0]         issue_lat_i,
    input  logic [NUM_SRC*5-1:0]     issue_rs_i,
    input  logic [NUM_SRC-1:0]       issue_rs_used_en,
    output logic                     stall_o,
    output logic [NUM_SRC*SEL_W-1:0] fwd_optn_o,
    output logic [CNT_W-1:0]         stall_count_o
);

    // Handshake: an instruction issues (issue_fire) in a cycle where issue_valid_i is
    // high, stall_o is low, hold_i is low and reset is inactive; otherwise it must be
    // presented again next cycle and stage 1 receives a bubble (unless held).
    logic issue_fire;

    logic             stg_valid [1:NUM_FWD_STAGES];
    logic [4:0]       stg_rd    [1:NUM_FWD_STAGES];
    logic             stg_we    [1:NUM_FWD_STAGES];
    logic [LAT_W-1:0] stg_lat   [1:NUM_FWD_STAGES];

    logic             issue_we_eff;
    logic [LAT_W-1:0] issue_lat_eff;

    logic [NUM_SRC-1:0] stall_req;
    logic [NUM_SRC-1:0] hit;
    logic [SEL_W-1:0]   hit_k   [NUM_SRC];
    logic [LAT_W-1:0]   hit_lat [NUM_SRC];
    logic [4:0]         rs      [NUM_SRC];

    assign issue_fire   = issue_valid_i & ~stall_o & ~hold_i & ~rst_i;
    assign issue_we_eff = issue_reg_write_en & (issue_rd_i != 5'd0);

    always_comb begin
        issue_lat_eff = issue_lat_i;
        if (issue_lat_i == '0) begin
            issue_lat_eff = LAT_W'(1);
        end else if (int'(issue_lat_i) > NUM_FWD_STAGES) begin
            issue_lat_eff = LAT_W'(NUM_FWD_STAGES);
        end
    end

    // Scanning oldest to youngest lets the youngest match overwrite older ones.
    always_comb begin
        stall_req  = '0;
        fwd_optn_o = '0;
        hit        = '0;
        for (int j = 0; j < NUM_SRC; j++) begin
            rs[j]      = issue_rs_i[5*j +: 5];
            hit_k[j]   = '0;
            hit_lat[j] = '0;
            for (int k = NUM_FWD_STAGES; k >= 1; k--) begin
                if (stg_valid[k] && stg_we[k] && (stg_rd[k] == rs[j]) &&
                    (rs[j] != 5'd0) && issue_rs_used_en[j]) begin
                    hit[j]     = 1'b1;
                    hit_k[j]   = SEL_W'(k);
                    hit_lat[j] = stg_lat[k];
                end
            end
            if (hit[j]) begin
                if (int'(hit_k[j]) >= int'(hit_lat[j])) begin
                    fwd_optn_o[j*SEL_W +: SEL_W] = hit_k[j];
                end else begin
                    stall_req[j] = 1'b1;
                end
            end
        end
        if (rst_i || !issue_valid_i) begin
            stall_req  = '0;
            fwd_optn_o = '0;
        end
    end

    assign stall_o = |stall_req;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int k = 1; k <= NUM_FWD_STAGES; k++) begin
                stg_valid[k] <= 1'b0;
            end
            stall_count_o <= '0;
        end else if (!hold_i) begin
            stg_valid[1] <= issue_fire;
            stg_rd[1]    <= issue_rd_i;
            stg_we[1]    <= issue_we_eff;
            stg_lat[1]   <= issue_lat_eff;
            for (int k = 2; k <= NUM_FWD_STAGES; k++) begin
                stg_valid[k] <= stg_valid[k-1];
                stg_rd[k]    <= stg_rd[k-1];
                stg_we[k]    <= stg_we[k-1];
                stg_lat[k]   <= stg_lat[k-1];
            end
            if (stall_o && (stall_count_o != '1)) begin
                stall_count_o <= stall_count_o + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_hazard_bypass_unit.sv
// Directed bench for hazard_bypass_unit: a 2-stage and a 4-stage instance share
// stimulus; each step pushes its expected {stall, selects, count} and checks it at negedge.
module tb_hazard_bypass_unit;

    logic       clk;
    logic       rst;
    logic       hold;
    logic       valid;
    logic [4:0] rd;
    logic       we;
    logic [2:0] lat;
    logic [9:0] rs;
    logic [1:0] used;

    logic        s2;
    logic [3:0]  f2;
    logic [31:0] c2;
    logic        s4;
    logic [5:0]  f4;
    logic [31:0] c4;

    logic [38:0] exp_q[$];
    int          checks;
    int          errors;
    logic [31:0] cnt2;
    logic [31:0] cnt4;

    hazard_bypass_unit #(.NUM_FWD_STAGES(2)) u2 (
        .clk_i(clk), .rst_i(rst), .hold_i(hold), .issue_valid_i(valid),
        .issue_rd_i(rd), .issue_reg_write_en(we), .issue_lat_i(lat[1:0]),
        .issue_rs_i(rs), .issue_rs_used_en(used),
        .stall_o(s2), .fwd_optn_o(f2), .stall_count_o(c2)
    );

    hazard_bypass_unit #(.NUM_FWD_STAGES(4)) u4 (
        .clk_i(clk), .rst_i(rst), .hold_i(hold), .issue_valid_i(valid),
        .issue_rd_i(rd), .issue_reg_write_en(we), .issue_lat_i(lat),
        .issue_rs_i(rs), .issue_rs_used_en(used),
        .stall_o(s4), .fwd_optn_o(f4), .stall_count_o(c4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input logic r, input logic v, input logic [4:0] d, input logic w,
                        input logic [2:0] l, input logic [4:0] rs1, input logic [4:0] rs0,
                        input logic [1:0] u, input logic h, input logic use4,
                        input logic e_stall, input logic [5:0] e_fwd, input string tag);
        logic [38:0] exp_v;
        logic [38:0] obs;
        rst   = r;
        valid = v;
        rd    = d;
        we    = w;
        lat   = l;
        rs    = {rs1, rs0};
        used  = u;
        hold  = h;
        exp_q.push_back({e_stall, e_fwd, (use4 ? cnt4 : cnt2)});
        @(negedge clk);
        exp_v = exp_q.pop_front();
        obs   = use4 ? {s4, f4, c4} : {s2, 2'b00, f2, c2};
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed stall=%b fwd=%h cnt=%0d, expected stall=%b fwd=%h cnt=%0d",
                   tag, obs[38], obs[37:32], obs[31:0], exp_v[38], exp_v[37:32], exp_v[31:0]);
        end
        if (r) begin
            cnt2 = 0;
            cnt4 = 0;
        end else if (e_stall && !h) begin
            if (use4) cnt4 = cnt4 + 1;
            else      cnt2 = cnt2 + 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic bubble();
        step(0, 0, 0, 0, 1, 0, 0, 2'b00, 0, 0, 0, 6'h00, "bubble");
    endtask

    initial begin
        checks = 0;
        errors = 0;
        cnt2   = 0;
        cnt4   = 0;
        rst = 1; hold = 0; valid = 1; rd = 0; we = 0; lat = 1; rs = {5'd0, 5'd5}; used = 2'b01;
        @(posedge clk);
        #1;

        // reset: outputs forced low even with a presented consumer
        step(1, 1, 0, 0, 1, 0, 5, 2'b01, 0, 0, 0, 6'h00, "reset_c1");
        step(1, 1, 0, 0, 1, 0, 5, 2'b01, 0, 0, 0, 6'h00, "reset_c2");
        step(1, 1, 0, 0, 1, 0, 5, 2'b01, 0, 0, 0, 6'h00, "reset_c3");
        step(0, 1, 0, 0, 1, 0, 5, 2'b01, 0, 0, 0, 6'h00, "reset_after");
        bubble(); bubble();

        // ALU chain
        step(0, 1, 5, 1, 1, 0, 0, 2'b00, 0, 0, 0, 6'h00, "alu_prod");
        step(0, 1, 0, 0, 1, 0, 5, 2'b01, 0, 0, 0, 6'h01, "alu_sel0_1");
        step(0, 1, 0, 0, 1, 5, 0, 2'b10, 0, 0, 0, 6'h08, "alu_sel1_2");
        bubble(); bubble();

        // load-use: exactly one stall, then stage-2 select
        step(0, 1, 6, 1, 2, 0, 0, 2'b00, 0, 0, 0, 6'h00, "ld_prod");
        step(0, 1, 0, 0, 1, 6, 0, 2'b10, 0, 0, 1, 6'h00, "ld_use_stall");
        step(0, 1, 0, 0, 1, 6, 0, 2'b10, 0, 0, 0, 6'h08, "ld_use_fwd");
        bubble(); bubble();

        // write-after-write: youngest (not ready) writer wins over ready older copy
        step(0, 1, 7, 1, 1, 0, 0, 2'b00, 0, 0, 0, 6'h00, "waw_old");
        step(0, 1, 7, 1, 2, 0, 0, 2'b00, 0, 0, 0, 6'h00, "waw_young");
        step(0, 1, 0, 0, 1, 0, 7, 2'b01, 0, 0, 1, 6'h00, "waw_stall");
        step(0, 1, 0, 0, 1, 0, 7, 2'b01, 0, 0, 0, 6'h02, "waw_fwd");
        bubble(); bubble();

        // x0 writer and reader
        step(0, 1, 0, 1, 2, 0, 0, 2'b00, 0, 0, 0, 6'h00, "x0_prod");
        step(0, 1, 0, 0, 1, 0, 0, 2'b01, 0, 0, 0, 6'h00, "x0_read");
        bubble(); bubble();

        // unused operand must not stall or select
        step(0, 1, 9, 1, 2, 0, 0, 2'b00, 0, 0, 0, 6'h00, "unused_prod");
        step(0, 1, 0, 0, 1, 9, 0, 2'b01, 0, 0, 0, 6'h00, "unused_read");
        bubble(); bubble();

        // two operands forwarding from different stages
        step(0, 1, 10, 1, 1, 0, 0, 2'b00, 0, 0, 0, 6'h00, "dual_p10");
        step(0, 1, 11, 1, 1, 0, 0, 2'b00, 0, 0, 0, 6'h00, "dual_p11");
        step(0, 1, 0, 0, 1, 10, 11, 2'b11, 0, 0, 0, 6'h09, "dual_sel");
        bubble(); bubble();

        // matching producer but no valid issue: no stall, no select
        step(0, 1, 12, 1, 2, 0, 0, 2'b00, 0, 0, 0, 6'h00, "novalid_prod");
        step(0, 0, 0, 0, 1, 0, 12, 2'b01, 0, 0, 0, 6'h00, "novalid_read");
        bubble(); bubble();

        // reset beats hold: the held producer must be flushed
        step(0, 1, 20, 1, 1, 0, 0, 2'b00, 0, 0, 0, 6'h00, "rsthold_prod");
        step(1, 1, 0, 0, 1, 0, 20, 2'b01, 1, 0, 0, 6'h00, "rsthold_rst");
        step(0, 1, 0, 0, 1, 0, 20, 2'b01, 0, 0, 0, 6'h00, "rsthold_flushed");
        step(0, 0, 0, 0, 1, 0, 0, 2'b00, 0, 1, 0, 6'h00, "d4_idle");

        // 4-stage depth: lat 3 producer, hold mid-stall
        step(0, 1, 3, 1, 3, 0, 0, 2'b00, 0, 1, 0, 6'h00, "d4_prod");
        step(0, 1, 0, 0, 1, 0, 3, 2'b01, 0, 1, 1, 6'h00, "d4_stall1");
        step(0, 1, 0, 0, 1, 0, 3, 2'b01, 1, 1, 1, 6'h00, "d4_hold1");
        step(0, 1, 0, 0, 1, 0, 3, 2'b01, 1, 1, 1, 6'h00, "d4_hold2");
        step(0, 1, 0, 0, 1, 0, 3, 2'b01, 0, 1, 1, 6'h00, "d4_stall2");
        step(0, 1, 0, 0, 1, 0, 3, 2'b01, 0, 1, 0, 6'h03, "d4_fwd3");
        step(0, 0, 0, 0, 1, 0, 0, 2'b00, 0, 1, 0, 6'h00, "d4_final_cnt");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
